// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and the weight-window-loader state encoding.
package cnn_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_KSIZE  = 2;
  localparam int DEF_HEIGHT = 32;
  localparam int N          = DEF_KSIZE * DEF_KSIZE;
  localparam int AW         = $clog2(DEF_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } wl_state_e;

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear; clear and increment in the same cycle yields 1.
module counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;
  logic [W-1:0] q_s;

  // Next count: optional clear, then optional increment
  always_comb begin
    q_s = q_r;
    if (clr) begin
      q_s = '0;
    end else begin
      q_s = q_r;
    end
    q_s = q_s + W'(inc);
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else begin
      q_r <= q_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/win_slot_reg.sv
// N x DW slot register file with indexed write; slot 0 sits in the LSBs of q.
module win_slot_reg #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IW-1:0]   idx,
  input  logic [DW-1:0]   wdata,
  output logic [N*DW-1:0] q
);

  logic [N-1:0][DW-1:0] slots_r;

  // Slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (we && (idx == IW'(i))) begin
          slots_r[i] <= wdata;
        end
      end
    end
  end

  assign q = slots_r;

endmodule

// File: rtl/weight_window_loader.sv
// Gathers KSIZE*KSIZE weight words from memory into one packed window for the PE stage.
// Optional macro WLOAD_DBL_BUF_EN adds ping-pong front/back window buffers.
module weight_window_loader
  import cnn_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DW     = DEF_DW,
  parameter int KSIZE  = DEF_KSIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(HEIGHT)-1:0]   addr_in,
  input  logic                        addr_valid,
  output logic                        addr_ready,
  output logic [$clog2(HEIGHT)-1:0]   mem_addr,
  output logic                        mem_rd,
  input  logic [DW-1:0]               mem_rdata,
  output logic [KSIZE*KSIZE*DW-1:0]   win_data,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic                        busy
);

  localparam int WIN_N = KSIZE * KSIZE;
  localparam int CNT_W = $clog2(WIN_N) + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIN_N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIN_N);

  wl_state_e        state_r;
  wl_state_e        state_s;
  logic             rd_pend_r;
  logic             win_valid_r;
  logic             win_valid_s;
  logic             addr_ready_s;
  logic             accept_s;
  logic             complete_s;
  logic             handshake_s;
  logic             wr_inc_s;
  logic [CNT_W-1:0] issued_r;
  logic [CNT_W-1:0] wr_idx_r;

  assign accept_s    = addr_valid && addr_ready_s;
  assign complete_s  = rd_pend_r && (wr_idx_r == LAST_SLOT);
  assign handshake_s = win_valid_r && win_ready;
  assign wr_inc_s    = rd_pend_r && !complete_s;

  counter #(.W(CNT_W)) u_issued (
    .clk (clk),
    .rst (rst),
    .clr (complete_s),
    .inc (accept_s),
    .q   (issued_r)
  );

  counter #(.W(CNT_W)) u_wr_idx (
    .clk (clk),
    .rst (rst),
    .clr (complete_s),
    .inc (wr_inc_s),
    .q   (wr_idx_r)
  );

`ifdef WLOAD_DBL_BUF_EN
  logic                  sel_r;
  logic                  swap_s;
  logic [WIN_N*DW-1:0]   buf0_s;
  logic [WIN_N*DW-1:0]   buf1_s;

  // A finished back buffer may swap forward only when the front is free or leaving now
  assign swap_s = (complete_s && (!win_valid_r || win_ready)) ||
                  ((state_r == HOLD) && win_ready);

  win_slot_reg #(.N(WIN_N), .DW(DW), .IW(CNT_W)) u_buf0 (
    .clk   (clk),
    .rst   (rst),
    .we    (rd_pend_r && sel_r),
    .idx   (wr_idx_r),
    .wdata (mem_rdata),
    .q     (buf0_s)
  );

  win_slot_reg #(.N(WIN_N), .DW(DW), .IW(CNT_W)) u_buf1 (
    .clk   (clk),
    .rst   (rst),
    .we    (rd_pend_r && !sel_r),
    .idx   (wr_idx_r),
    .wdata (mem_rdata),
    .q     (buf1_s)
  );

  // Front/back selector flips on every swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r <= 1'b0;
    end else begin
      sel_r <= sel_r ^ swap_s;
    end
  end

  assign win_data = sel_r ? buf1_s : buf0_s;
  assign busy     = (state_r != IDLE) || rd_pend_r || win_valid_r;
`else
  win_slot_reg #(.N(WIN_N), .DW(DW), .IW(CNT_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (rd_pend_r),
    .idx   (wr_idx_r),
    .wdata (mem_rdata),
    .q     (win_data)
  );

  assign busy = (state_r != IDLE) || rd_pend_r;
`endif

  // Next-state, address-ready and window-valid decode
  always_comb begin
    state_s      = state_r;
    addr_ready_s = 1'b0;
    win_valid_s  = win_valid_r;
    case (state_r)
      IDLE: begin
        if (addr_valid) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
`ifdef WLOAD_DBL_BUF_EN
        addr_ready_s = (issued_r < FULL_CNT) || (complete_s && swap_s);
        if (complete_s && swap_s) begin
          state_s = addr_valid ? LOAD : IDLE;
        end else if (complete_s) begin
          state_s = HOLD;
        end else begin
          state_s = LOAD;
        end
`else
        addr_ready_s = (issued_r < FULL_CNT);
        if (complete_s) begin
          state_s = HOLD;
        end else begin
          state_s = LOAD;
        end
`endif
      end
      HOLD: begin
        if (handshake_s) begin
          state_s = addr_valid ? LOAD : IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

`ifdef WLOAD_DBL_BUF_EN
    if (swap_s) begin
      win_valid_s = 1'b1;
    end else if (handshake_s) begin
      win_valid_s = 1'b0;
    end else begin
      win_valid_s = win_valid_r;
    end
`else
    if (complete_s) begin
      win_valid_s = 1'b1;
    end else if (handshake_s) begin
      win_valid_s = 1'b0;
    end else begin
      win_valid_s = win_valid_r;
    end
`endif
  end

  // State, pending-read and window-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rd_pend_r   <= 1'b0;
      win_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rd_pend_r   <= accept_s;
      win_valid_r <= win_valid_s;
    end
  end

  assign addr_ready = addr_ready_s;
  assign mem_rd     = accept_s;
  assign mem_addr   = accept_s ? addr_in : '0;
  assign win_valid  = win_valid_r;

endmodule

// File: tb/tb_weight_window_loader.sv
// Randomized self-checking bench for weight_window_loader against a window-level reference model.
module tb_weight_window_loader;
  import cnn_pkg::*;

  localparam int DW     = DEF_DW;
  localparam int HEIGHT = DEF_HEIGHT;
`ifdef WLOAD_DBL_BUF_EN
  localparam int PERIOD = N;
`else
  localparam int PERIOD = N + 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     addr_in = '0;
  logic              addr_valid = 1'b0;
  logic              addr_ready;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic [DW-1:0]     mem_rdata = '0;
  logic [N*DW-1:0]   win_data;
  logic              win_valid;
  logic              win_ready = 1'b0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   mem [HEIGHT];
  logic [AW-1:0]   feed_q[$];
  logic [AW-1:0]   acc_q[$];
  int              acc_cyc_q[$];
  logic [N*DW-1:0] got_q[$];
  int              rise_q[$];
  int              ncyc = 0;
  logic            prev_valid = 1'b0;
  int              sent = 0;
  int              gap_at = -1;
  int              gap_len = 0;
  bit              rnd = 1'b0;
  logic            ready_val = 1'b1;

  weight_window_loader #(.HEIGHT(HEIGHT), .DW(DW), .KSIZE(DEF_KSIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .win_data   (win_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Record accepted addresses, delivered windows and win_valid rises
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (addr_valid && addr_ready) begin
        acc_q.push_back(addr_in);
        acc_cyc_q.push_back(ncyc);
      end
      if (win_valid && win_ready) got_q.push_back(win_data);
      if (win_valid && !prev_valid) rise_q.push_back(ncyc);
      prev_valid <= win_valid;
    end
  end

  // Reference: window w is the memory words at accepted addresses w*N .. w*N+N-1
  function automatic logic [N*DW-1:0] exp_win(input int w);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = mem[acc_q[w*N+i]];
    return r;
  endfunction

  task automatic clear_model();
    feed_q.delete(); acc_q.delete(); acc_cyc_q.delete(); got_q.delete(); rise_q.delete();
    sent = 0; gap_at = -1; gap_len = 0;
  endtask

  task automatic fill_mem(input bit random);
    for (int a = 0; a < HEIGHT; a++) mem[a] = random ? DW'($urandom) : DW'(a + 1);
  endtask

  // Drive the address stream and win_ready for a bounded number of cycles
  task automatic run(input int cycles);
    int gl;
    gl = gap_len;
    for (int c = 0; c < cycles; c++) begin
      if (sent == gap_at && gl > 0) begin
        addr_valid = 1'b0; gl--;
      end else if (feed_q.size() > 0 && !(rnd && $urandom_range(3, 0) == 0)) begin
        addr_valid = 1'b1; addr_in = feed_q[0];
      end else begin
        addr_valid = 1'b0;
      end
      win_ready = rnd ? ($urandom_range(2, 0) != 0) : ready_val;
      @(negedge clk);
      if (addr_valid && addr_ready) begin
        void'(feed_q.pop_front()); sent++;
      end
      @(posedge clk); #1;
    end
    addr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL reset_addr_ready: got %b want 0", addr_ready); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h want 0", win_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [N*DW-1:0] exp;
    logic [AW-1:0]   fa;
    fill_mem(1'b0); clear_model(); rnd = 1'b0; ready_val = 1'b1;
    for (int i = 0; i < N; i++) feed_q.push_back(AW'(i + 8));
    run(4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midload_busy: got %b want 1", busy); end
    rst = 1'b1; #1;
    checks++;
    if ({addr_ready, mem_rd, mem_addr, win_valid, win_data, busy} !== '0) begin
      errors++; $display("FAIL midload_reset_outputs: got rdy=%b rd=%b addr=%h v=%b data=%h busy=%b want all 0",
                         addr_ready, mem_rd, mem_addr, win_valid, win_data, busy);
    end
    repeat (2) @(posedge clk); #1;
    clear_model(); rst = 1'b0;
    exp = '0;
    for (int i = 0; i < N; i++) begin
      fa = AW'(20 + i); feed_q.push_back(fa); exp[i*DW +: DW] = mem[fa];
    end
    run(12);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midload_win_count: got %0d want 1", got_q.size()); end
    checks++; if (got_q[0] !== exp) begin errors++; $display("FAIL midload_fresh_data: got %h want %h", got_q[0], exp); end
  endtask

  task automatic test_single_window();
    fill_mem(1'b0); clear_model(); ready_val = 1'b1;
    feed_q.push_back(5'd0); feed_q.push_back(5'd16); feed_q.push_back(5'd1); feed_q.push_back(5'd17);
    run(10);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    checks++; if (got_q[0] !== 32'h12021101) begin errors++; $display("FAIL single_data_const: got %h want 12021101", got_q[0]); end
    checks++; if (got_q[0] !== exp_win(0)) begin errors++; $display("FAIL single_data_model: got %h want %h", got_q[0], exp_win(0)); end
    checks++; if (rise_q[0] - acc_cyc_q[0] !== N + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", rise_q[0] - acc_cyc_q[0], N + 1); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_gap();
    fill_mem(1'b0); clear_model(); ready_val = 1'b1;
    feed_q.push_back(5'd0); feed_q.push_back(5'd16); feed_q.push_back(5'd1); feed_q.push_back(5'd17);
    gap_at = 2; gap_len = 3;
    run(14);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL gap_count: got %0d want 1", got_q.size()); end
    checks++; if (got_q[0] !== 32'h12021101) begin errors++; $display("FAIL gap_data: got %h want 12021101", got_q[0]); end
    checks++; if (rise_q[0] - acc_cyc_q[0] !== N + 4) begin errors++; $display("FAIL gap_latency: got %0d want %0d", rise_q[0] - acc_cyc_q[0], N + 4); end
  endtask

  task automatic test_backpressure();
    fill_mem(1'b1); clear_model(); ready_val = 1'b0;
    for (int i = 0; i < 3 * N; i++) feed_q.push_back(AW'($urandom));
    run(14);
    for (int c = 0; c < 10; c++) begin
      addr_valid = (feed_q.size() > 0); addr_in = feed_q[0]; win_ready = 1'b0;
      @(negedge clk);
      checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, win_valid); end
      checks++; if (win_data !== exp_win(0)) begin errors++; $display("FAIL bp_data c%0d: got %h want %h", c, win_data, exp_win(0)); end
      checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL bp_addr_ready c%0d: got %b want 0", c, addr_ready); end
      if (addr_valid && addr_ready) begin void'(feed_q.pop_front()); sent++; end
      @(posedge clk); #1;
    end
    ready_val = 1'b1;
    run(30);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int w = 0; w < got_q.size(); w++) begin
      checks++; if (got_q[w] !== exp_win(w)) begin errors++; $display("FAIL bp_win%0d: got %h want %h", w, got_q[w], exp_win(w)); end
    end
  endtask

  task automatic test_back_to_back();
    fill_mem(1'b1); clear_model(); ready_val = 1'b1;
    for (int i = 0; i < 3 * N; i++) feed_q.push_back(AW'($urandom));
    run(30);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_q.size()); end
    checks++; if (rise_q[1] - rise_q[0] !== PERIOD) begin errors++; $display("FAIL b2b_period01: got %0d want %0d", rise_q[1] - rise_q[0], PERIOD); end
    checks++; if (rise_q[2] - rise_q[1] !== PERIOD) begin errors++; $display("FAIL b2b_period12: got %0d want %0d", rise_q[2] - rise_q[1], PERIOD); end
    for (int w = 0; w < got_q.size(); w++) begin
      checks++; if (got_q[w] !== exp_win(w)) begin errors++; $display("FAIL b2b_win%0d: got %h want %h", w, got_q[w], exp_win(w)); end
    end
  endtask

`ifdef WLOAD_DBL_BUF_EN
  task automatic test_dbl_stall();
    fill_mem(1'b1); clear_model(); ready_val = 1'b0;
    for (int i = 0; i < 3 * N; i++) feed_q.push_back(AW'($urandom));
    run(14);
    addr_valid = 1'b1; addr_in = feed_q[0]; win_ready = 1'b0;
    @(negedge clk);
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL dbl_full_ready: got %b want 0", addr_ready); end
    checks++; if (win_data !== exp_win(0)) begin errors++; $display("FAIL dbl_front: got %h want %h", win_data, exp_win(0)); end
    @(posedge clk); #1;
    win_ready = 1'b1;
    @(negedge clk);
    checks++; if ({win_valid, addr_ready} !== 2'b10) begin errors++; $display("FAIL dbl_pulse: got v/rdy=%b want 10", {win_valid, addr_ready}); end
    @(posedge clk); #1;
    win_ready = 1'b0;
    @(negedge clk);
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL dbl_ready_rise: got %b want 1", addr_ready); end
    checks++; if (win_data !== exp_win(1)) begin errors++; $display("FAIL dbl_swapped: got %h want %h", win_data, exp_win(1)); end
    if (addr_valid && addr_ready) begin void'(feed_q.pop_front()); sent++; end
    @(posedge clk); #1;
    ready_val = 1'b1;
    run(30);
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL dbl_count: got %0d want 3", got_q.size()); end
    for (int w = 0; w < got_q.size(); w++) begin
      checks++; if (got_q[w] !== exp_win(w)) begin errors++; $display("FAIL dbl_win%0d: got %h want %h", w, got_q[w], exp_win(w)); end
    end
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] fed[$];
    fill_mem(1'b1); clear_model();
    for (int i = 0; i < 5 * N; i++) begin
      fed.push_back(AW'($urandom)); feed_q.push_back(fed[i]);
    end
    rnd = 1'b1;
    run(200);
    rnd = 1'b0; ready_val = 1'b1;
    run(10);
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL rand_count: got %0d want 5", got_q.size()); end
    checks++; if (acc_q.size() !== 5 * N) begin errors++; $display("FAIL rand_accepts: got %0d want %0d", acc_q.size(), 5 * N); end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== fed[i]) begin errors++; $display("FAIL rand_addr%0d: got %h want %h", i, acc_q[i], fed[i]); end
    end
    for (int w = 0; w < got_q.size(); w++) begin
      checks++; if (got_q[w] !== exp_win(w)) begin errors++; $display("FAIL rand_win%0d: got %h want %h", w, got_q[w], exp_win(w)); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_single_window();
    test_addr_gap();
    test_backpressure();
    test_back_to_back();
`ifdef WLOAD_DBL_BUF_EN
    test_dbl_stall();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
